// File: rtl/inst_fetch_buffer.sv
// Fetch front end: drives ROM address, queues returned words with their PC,
// and hands the queue head to decode under a valid/ready handshake.
module inst_fetch_buffer #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INST_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       rom_ce_o,
  output logic [ADDR_W-1:0]          rom_addr_o,
  input  logic [INST_W-1:0]          rom_data_i,
  output logic                       inst_valid_o,
  output logic [INST_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          pc_o,
  input  logic                       id_ready_i,
  input  logic                       flush_i,
  input  logic [ADDR_W-1:0]          flush_pc_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              ce_q, ce_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [INST_W-1:0] inst_mem_d [DEPTH];

  logic pop;
  logic push;
  logic not_full;

  assign rom_ce_o     = ce_q;
  assign rom_addr_o   = fetch_pc_q;
  assign count_o      = count_q;
  assign inst_valid_o = (count_q != '0);
  assign inst_o       = inst_valid_o ? inst_mem_q[rptr_q] : '0;
  assign pc_o         = inst_valid_o ? pc_mem_q[rptr_q] : '0;

  // Handshake decode: a full queue may still accept when the head leaves.
  always_comb begin
    pop      = inst_valid_o & id_ready_i;
    not_full = (count_q < FULL);
    push     = ce_q & ~flush_i & (not_full | pop);
  end

  // Next-state: redirect wipes the queue and reloads the word-aligned PC.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    ce_d       = 1'b1;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    if (flush_i) begin
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
      fetch_pc_d = flush_pc_i & ~ADDR_W'(3);
    end else begin
      if (push) begin
        wptr_d     = wptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Storage next-state: write the fetched word and its PC at the tail.
  always_comb begin
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (push) begin
      pc_mem_d[wptr_q]   = fetch_pc_q;
      inst_mem_d[wptr_q] = rom_data_i;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      ce_q       <= 1'b0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ce_q       <= ce_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; contents are masked by the occupancy count.
  always_ff @(posedge clk) begin
    pc_mem_q   <= pc_mem_d;
    inst_mem_q <= inst_mem_d;
  end

endmodule
